// File: rtl/snn_stage_seq.sv
// snn_stage_seq: top-level sequencer for the SNN inference datapath.
// Captures the serial input stream, then runs conv/quant/pool/dense/dense-quant
// once per image with start/done handshakes, latches vector 0 between the two
// passes and times the distance/activation tail before strobing the result.
// Optional macro SNN_SEQ_WATCHDOG_EN adds a per-stage watchdog and sticky wd_err.
module snn_stage_seq #(
  parameter int unsigned LOAD_LEN = 72,
  parameter int unsigned N_STG    = 5,
  parameter int unsigned FIN_LAT  = 2
`ifdef SNN_SEQ_WATCHDOG_EN
  , parameter int unsigned WD_LEN = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N_STG-1:0] stage_done,
  output logic             load_we,
  output logic [6:0]       load_addr,
  output logic [N_STG-1:0] stage_start,
  output logic             img_sel,
  output logic             vec0_latch,
  output logic             fin_start,
  output logic             out_strobe,
  output logic             busy,
  output logic [2:0]       state_o
`ifdef SNN_SEQ_WATCHDOG_EN
  , output logic           wd_err
`endif
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned FCNT_W = $clog2(FIN_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, CONV = 3'd2, QUAN = 3'd3,
    POOL = 3'd4, DENS = 3'd5, QUAD = 3'd6, FIN  = 3'd7
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [N_STG-1:0]    start_n, cur_oh;
  logic                img_n, vec0_n, fin_n, strobe_n, done_hit;
  logic [FCNT_W-1:0]   fcnt, fcnt_n;

`ifdef SNN_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_LEN);
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            wd_n, in_stage;
  assign in_stage = |cur_oh;
`endif

  assign state_o = 3'(state);
  assign load_we = in_valid && ((state == IDLE) || (state == LOAD));

  // One-hot of the engine owned by the current stage state.
  always_comb begin
    cur_oh = '0;
    unique case (state)
      CONV:    cur_oh[0] = 1'b1;
      QUAN:    cur_oh[1] = 1'b1;
      POOL:    cur_oh[2] = 1'b1;
      DENS:    cur_oh[3] = 1'b1;
      QUAD:    cur_oh[4] = 1'b1;
      default: cur_oh = '0;
    endcase
  end

  // Done only counts for the active stage and never on its own start cycle.
  assign done_hit = (|(stage_done & cur_oh)) && !(|stage_start);

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    addr_n   = load_addr;
    start_n  = '0;
    img_n    = img_sel;
    vec0_n   = 1'b0;
    fin_n    = 1'b0;
    strobe_n = 1'b0;
    fcnt_n   = fcnt;
`ifdef SNN_SEQ_WATCHDOG_EN
    wd_cnt_n = wd_cnt;
    wd_n     = wd_err;
`endif
    unique case (state)
      IDLE: if (in_valid) begin
        state_n = LOAD;
        addr_n  = ADDR_W'(1);
      end
      LOAD: if (in_valid) begin
        if (load_addr == LAST_ADDR) begin
          state_n = CONV;
          addr_n  = '0;
          img_n   = 1'b0;
          start_n = N_STG'(1);
        end else begin
          addr_n = load_addr + ADDR_W'(1);
        end
      end
      CONV, QUAN, POOL, DENS: if (done_hit) begin
        state_n = state_t'(3'(state) + 3'd1);
        start_n = cur_oh << 1;
      end
      QUAD: if (done_hit) begin
        if (!img_sel) begin
          state_n = CONV;
          img_n   = 1'b1;
          vec0_n  = 1'b1;
          start_n = N_STG'(1);
        end else begin
          state_n = FIN;
          fin_n   = 1'b1;
          fcnt_n  = '0;
        end
      end
      FIN: begin
        if (fcnt == FCNT_W'(FIN_LAT)) begin
          state_n  = IDLE;
          strobe_n = 1'b1;
          img_n    = 1'b0;
        end else begin
          fcnt_n = fcnt + FCNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SNN_SEQ_WATCHDOG_EN
    if (start_n != '0) begin
      wd_cnt_n = '0;
    end else if (in_stage && !done_hit) begin
      if (wd_cnt == WD_W'(WD_LEN - 1)) begin
        state_n  = IDLE;
        start_n  = '0;
        vec0_n   = 1'b0;
        img_n    = 1'b0;
        wd_n     = 1'b1;
        wd_cnt_n = '0;
      end else begin
        wd_cnt_n = wd_cnt + WD_W'(1);
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_n;
  end

  // Registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      load_addr   <= '0;
      stage_start <= '0;
      img_sel     <= 1'b0;
      vec0_latch  <= 1'b0;
      fin_start   <= 1'b0;
      out_strobe  <= 1'b0;
      busy        <= 1'b0;
      fcnt        <= '0;
`ifdef SNN_SEQ_WATCHDOG_EN
      wd_cnt      <= '0;
      wd_err      <= 1'b0;
`endif
    end else begin
      load_addr   <= addr_n;
      stage_start <= start_n;
      img_sel     <= img_n;
      vec0_latch  <= vec0_n;
      fin_start   <= fin_n;
      out_strobe  <= strobe_n;
      busy        <= (state_n != IDLE);
      fcnt        <= fcnt_n;
`ifdef SNN_SEQ_WATCHDOG_EN
      wd_cnt      <= wd_cnt_n;
      wd_err      <= wd_n;
`endif
    end
  end

endmodule

// File: tb/tb_snn_stage_seq.sv
// tb_snn_stage_seq: directed bench for snn_stage_seq with a stage-index model
// (global stage number 0..9 across both images) and literal end-of-run checks.
// Watchdog scenario compiled only with SNN_SEQ_WATCHDOG_EN.
module tb_snn_stage_seq;
  localparam int unsigned LOAD_LEN = 72;
  localparam int unsigned N_STG    = 5;
  localparam int unsigned FIN_LAT  = 2;
  localparam int unsigned WD_LEN   = 64;

  logic       clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0;
  logic [4:0] stage_done = '0;
  logic       load_we, img_sel, vec0_latch, fin_start, out_strobe, busy;
  logic [6:0] load_addr;
  logic [4:0] stage_start;
  logic [2:0] state_o;
`ifdef SNN_SEQ_WATCHDOG_EN
  logic       wd_err;
`endif

  int tests = 0, fails = 0, cyc = 0;

  snn_stage_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stage_done(stage_done),
    .load_we(load_we), .load_addr(load_addr), .stage_start(stage_start),
    .img_sel(img_sel), .vec0_latch(vec0_latch), .fin_start(fin_start),
    .out_strobe(out_strobe), .busy(busy), .state_o(state_o)
`ifdef SNN_SEQ_WATCHDOG_EN
    , .wd_err(wd_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine responder: done the cycle after start, with optional slow POOL,
  // a stray DENS bit during POOL, and a withheld QUAN done.
  int         wait_cnt = 0, spur_cyc = -1;
  logic [4:0] pend = '0;
  bit         slow_pool = 0, spur_en = 0, hold_quan = 0;
  always @(posedge clk) begin
    #1;
    stage_done = '0;
    if (rst_n) begin
      wait_cnt = 0;
    end else begin
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) stage_done = pend;
        else if (spur_en && pend == 5'b00100 && wait_cnt == 5) begin
          stage_done = 5'b01000;
          spur_cyc   = cyc;
          spur_en    = 0;
        end
      end
      if (stage_start != '0) begin
        pend     = stage_start;
        wait_cnt = 1;
        if (stage_start == 5'b00100 && slow_pool) begin
          wait_cnt  = 11;
          slow_pool = 0;
        end
        if (stage_start == 5'b00010 && hold_quan) wait_cnt = 0;
      end
    end
  end

  // Behavioural model: phase 0 idle, 1 load, 2 stage g (0..9), 3 tail.
  int         m_ph = 0, m_g = 0, m_age = 0, m_fage = 0;
  logic [6:0] m_addr = '0;
  logic [4:0] m_start = '0;
  logic       m_vec0 = 0, m_fin = 0, m_strobe = 0, m_wd = 0;
  always @(posedge clk) begin
    m_start = '0; m_vec0 = 0; m_fin = 0; m_strobe = 0;
    if (rst_n) begin
      m_ph = 0; m_g = 0; m_addr = '0; m_age = 0; m_fage = 0; m_wd = 0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin m_ph = 1; m_addr = 7'd1; end
        1: if (in_valid) begin
          if (int'(m_addr) == LOAD_LEN - 1) begin
            m_ph = 2; m_g = 0; m_age = 0; m_addr = '0; m_start = 5'd1;
          end else m_addr++;
        end
        2: begin
          if (m_age >= 1 && stage_done[m_g % N_STG]) begin
            m_g++;
            if (m_g == 2 * N_STG) begin
              m_ph = 3; m_fin = 1; m_fage = 0;
            end else begin
              m_vec0  = (m_g == N_STG);
              m_start = 5'(1 << (m_g % N_STG));
              m_age   = 0;
            end
          end
`ifdef SNN_SEQ_WATCHDOG_EN
          else if (m_age == WD_LEN - 1) begin
            m_ph = 0; m_g = 0; m_wd = 1;
          end
`endif
          else m_age++;
        end
        default: begin
          if (m_fage == FIN_LAT) begin
            m_ph = 0; m_strobe = 1; m_g = 0;
          end else m_fage++;
        end
      endcase
    end
  end

  // Every-cycle compare against the model.
  bit armed = 0;
  always @(negedge clk) begin
    if (armed) begin
      chk("load_we", load_we, in_valid && m_ph <= 1);
      chk("load_addr", load_addr, m_addr);
      chk("stage_start", stage_start, m_start);
      chk("img_sel", img_sel, m_ph >= 2 && m_g >= N_STG);
      chk("vec0_latch", vec0_latch, m_vec0);
      chk("fin_start", fin_start, m_fin);
      chk("out_strobe", out_strobe, m_strobe);
      chk("busy", busy, m_ph != 0);
      chk("state_o", state_o, m_ph == 0 ? 0 : m_ph == 1 ? 1 : m_ph == 2 ? 2 + m_g % N_STG : 7);
`ifdef SNN_SEQ_WATCHDOG_EN
      chk("wd_err", wd_err, m_wd);
`endif
    end
  end

  // Event recorder for per-run literal checks.
  logic [4:0] seq[$];
  int vec0_cnt = 0, vec0_at = -1, beats = 0, last_beat_cyc = -1, strobe_cyc = -1;
  int quan_cyc = -1, wd_cyc = -1;
  always @(negedge clk) begin
    if (armed) begin
      if (load_we) begin
        beats++;
        if (load_addr == 7'd71) last_beat_cyc = cyc;
      end
      if (vec0_latch) begin vec0_cnt++; vec0_at = seq.size(); end
      if (stage_start != '0) begin
        seq.push_back(stage_start);
        if (seq.size() == 1) chk("beats_before_conv", beats, 72);
        if (stage_start == 5'b00010 && quan_cyc < 0) quan_cyc = cyc;
      end
      if (out_strobe) strobe_cyc = cyc;
      if (cyc == spur_cyc) chk("state_at_stray_done", state_o, 4);
`ifdef SNN_SEQ_WATCHDOG_EN
      if (wd_err && wd_cyc < 0) wd_cyc = cyc;
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_run();
    seq.delete();
    vec0_cnt = 0; vec0_at = -1; beats = 0; last_beat_cyc = -1;
    strobe_cyc = -1; quan_cyc = -1; wd_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    armed = 1;
  endtask

  task automatic do_load(input bit stall);
    for (int i = 0; i < LOAD_LEN; i++) begin
      if (stall && i == 31) begin
        in_valid = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_addr", load_addr, 31);
          chk("stall_we", load_we, 0);
          tick();
        end
      end
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (strobe_cyc < 0 && n < 300) begin tick(); n++; end
    chk({tag, "_strobe_seen"}, n < 300, 1);
  endtask

  task automatic check_run(input string tag, input int lat);
    logic [4:0] exp_seq [10] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
    chk({tag, "_n_starts"}, seq.size(), 10);
    for (int i = 0; i < 10 && i < seq.size(); i++) chk({tag, "_start_order"}, seq[i], exp_seq[i]);
    chk({tag, "_vec0_count"}, vec0_cnt, 1);
    chk({tag, "_vec0_position"}, vec0_at, 5);
    chk({tag, "_latency"}, strobe_cyc - last_beat_cyc, lat);
    @(negedge clk);
    chk({tag, "_idle_state"}, state_o, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    tick();
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", load_addr, 0);
    chk("rst_start", stage_start, 0);
    chk("rst_img", img_sel, 0);
    tick();

    // Basic run.
    clear_run();
    do_load(0);
    wait_strobe("basic");
    check_run("basic", 24);

    // Stalled load.
    clear_run();
    do_load(1);
    wait_strobe("stall");
    check_run("stall", 24);

    // Slow POOL done with a stray DENS bit; in_valid poked during FIN.
    clear_run();
    slow_pool = 1; spur_en = 1;
    do_load(0);
    begin
      int n = 0;
      while (state_o != 3'd7 && n < 300) begin tick(); n++; end
      chk("fin_reached", state_o, 7);
    end
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    wait_strobe("slow");
    chk("stray_done_fired", spur_cyc >= 0, 1);
    check_run("slow", 34);

    // Mid-operation reset in DENS of image 1, then a fresh run.
    clear_run();
    do_load(0);
    begin
      int n = 0;
      while (!(state_o == 3'd5 && img_sel) && n < 300) begin tick(); n++; end
      chk("dens_img1_reached", n < 300, 1);
    end
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", state_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_start", stage_start, 0);
    chk("midrst_img", img_sel, 0);
    chk("midrst_pulses", {vec0_latch, fin_start, out_strobe}, 0);
    chk("midrst_addr", load_addr, 0);
    repeat (3) tick();
    clear_run();
    do_load(0);
    wait_strobe("rerun");
    check_run("rerun", 24);

`ifdef SNN_SEQ_WATCHDOG_EN
    // Withheld QUAN done trips the watchdog.
    clear_run();
    hold_quan = 1;
    do_load(0);
    begin
      int n = 0;
      while (wd_cyc < 0 && n < 200) begin tick(); n++; end
      chk("wd_fired", n < 200, 1);
    end
    chk("wd_delay", wd_cyc - quan_cyc, WD_LEN);
    @(negedge clk);
    chk("wd_state", state_o, 0);
    chk("wd_img", img_sel, 0);
    hold_quan = 0;
    repeat (10) tick();
    chk("wd_sticky", wd_err, 1);
    do_reset();
    @(negedge clk);
    chk("wd_cleared", wd_err, 0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snn_stage_seq.md
Name: snn_stage_seq

Overview:
- Top-level sequencer for the SNN inference datapath: conv, quant, maxpool, dense and dense-quant engines, plus the L1-distance/activation tail.
- Captures the serial input stream and issues per-stage start pulses, waiting on each engine's done.
- Runs the stage chain once per image (two images), latches the first feature vector, then times the distance/activation tail and strobes the result.
- Replaces free-running fixed-count scheduling with explicit start/done handshakes.

Parameters:
- LOAD_LEN, 72, number of accepted input beats per inference (2x 6x6 images).
- N_STG, 5, number of per-image stages (CONV, QUAN, POOL, DENS, QUAD).
- FIN_LAT, 2, cycles from fin_start to valid distance/activation result.
- WD_LEN, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: synchronous, active-high (asserted = 1). Name kept per codebase convention.
- in_valid  input  1  input beat valid.
- stage_done  input  N_STG  per-stage done pulses; bit k = stage k.
- load_we  output  1  write enable to the input buffers (combinational).
- load_addr  output  7  beat index 0..LOAD_LEN-1 (registered).
- stage_start  output  N_STG  one-hot start pulse (registered).
- img_sel  output  1  0 = image 0, 1 = image 1 feeds conv.
- vec0_latch  output  1  pulse: capture quad output as vector 0.
- fin_start  output  1  pulse: start the distance/activation tail.
- out_strobe  output  1  pulse: result valid; downstream registers out_data.
- busy  output  1  high in every state except IDLE.
- state_o  output  3  current state encoding.

Behaviour:
- States and encodings: IDLE=0, LOAD=1, CONV=2, QUAN=3, POOL=4, DENS=5, QUAD=6, FIN=7.
- Reset: state IDLE. All outputs 0: load_addr, stage_start, img_sel, vec0_latch, fin_start, out_strobe, busy. Internal counters cleared.
- Reset mid-operation: aborts at that edge with no further pulses. Stale stage_done after reset is ignored.
- Load handshake:
  - load_we = in_valid while in IDLE or LOAD.
  - IDLE with in_valid=1: beat 0 written at load_addr=0; go to LOAD.
  - load_addr increments on each accepted beat. A gap in in_valid during LOAD holds the address (stall, no timeout).
  - Beat LOAD_LEN-1 accepted: next state CONV with img_sel=0, load_addr back to 0.
  - in_valid outside IDLE/LOAD is ignored; load_we=0.
- Stage handshake:
  - On the cycle a stage state is entered, stage_start[k] = 1 for exactly one cycle; otherwise 0.
  - stage_done[k] is sampled from the cycle after the start pulse. Done on the start cycle, or done bits for other stages, are ignored.
  - On the edge sampling done=1: advance CONV->QUAN->POOL->DENS->QUAD. The next start follows one cycle after done.
- Image loop:
  - QUAD done with img_sel=0: vec0_latch pulses one cycle (the cycle after done), img_sel<=1, enter CONV.
  - QUAD done with img_sel=1: enter FIN.
- FIN:
  - fin_start pulses on entry; internal counter runs FIN_LAT cycles.
  - out_strobe pulses on the cycle after the counter expires, then IDLE with img_sel<=0.
- Minimum latency (all done pulses arrive the cycle after start):
  - last load beat -> first CONV start: 1 cycle.
  - each stage: 2 cycles.
  - last load beat -> out_strobe: 1 + 2*N_STG*2 + FIN_LAT + 1 = 24 cycles at defaults.
- No back-to-back overlap: a new in_valid during FIN is ignored. A new inference starts only from IDLE.

Optional Feature:
- Macro SNN_SEQ_WATCHDOG_EN.
- Defined:
  - A per-stage cycle counter clears on each stage_start.
  - If done has not arrived after WD_LEN cycles, the block asserts extra output wd_err (1-bit sticky), forces IDLE with all pulses 0, and clears img_sel.
  - wd_err clears only on reset.
- Undefined: no counter, no wd_err port; the block waits indefinitely for done.

Test Plan:
- Basic run:
  - Stimulus: reset, then 72 contiguous in_valid beats; every stage_done returned the cycle after its start.
  - Response: load_addr 0..71; ten start pulses in order C,Q,P,D,QD x2; vec0_latch once, between the two passes; out_strobe exactly 24 cycles after beat 71; busy drops with return to IDLE.
- Stalled load:
  - Stimulus: in_valid low for 5 cycles after beat 30.
  - Response: load_addr holds at 31; load_we=0 during the gap; CONV is entered only after 72 accepted beats.
- Slow and spurious done:
  - Stimulus: POOL done delayed 10 cycles; a DENS done bit pulsed during POOL.
  - Response: state stays POOL (4) until the POOL done; the stray bit is ignored; no skipped start.
- Mid-operation reset:
  - Stimulus: rst_n=1 in DENS of image 1 for one cycle, then a full new inference.
  - Response: all outputs 0 the next cycle; state_o=0; second run identical to the basic run.
- Watchdog (SNN_SEQ_WATCHDOG_EN, WD_LEN=64):
  - Stimulus: withhold QUAN done.
  - Response: wd_err=1 64 cycles after the QUAN start, state IDLE, wd_err stays 1 until reset.
